// File: rtl/mtm_alu_serializer_pkg.sv
// Shared types, frame constants and CTL-byte builders for the ALU response serializer.
package mtm_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_DATA = 2'd1,
        ST_SEND_CTL  = 2'd2
    } state_e;

    localparam logic START      = 1'b0;
    localparam logic STOP       = 1'b1;
    localparam logic TYPE_DATA  = 1'b0;
    localparam logic TYPE_CTL   = 1'b1;
    localparam int   FRAME_BITS = 11;

    function automatic logic [7:0] norm_ctl_byte(input logic [3:0] flags, input logic [2:0] crc);
        return {1'b0, flags, crc};
    endfunction

    // Parity bit makes the whole byte even; with the doubled flags it always ends up 1.
    function automatic logic [7:0] err_ctl_byte(input logic [2:0] err_flags);
        logic [6:0] upper;
        upper = {1'b1, err_flags, err_flags};
        return {upper, ^upper};
    endfunction

    function automatic logic [7:0] result_byte(input logic [31:0] result, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = result[31:24];
            2'd1:    b = result[23:16];
            2'd2:    b = result[15:8];
            default: b = result[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Response handshake and serial line between the ALU core side and the serializer.
interface mtm_alu_serializer_if;
    logic        res_valid;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [2:0]  crc;
    logic        err_valid;
    logic [2:0]  err_flags;
    logic        res_ack;
    logic        err_ack;
    logic        busy;
    logic        sout;

    modport slave (
        input  res_valid, result, flags, crc, err_valid, err_flags,
        output res_ack, err_ack, busy, sout
    );

    modport master (
        output res_valid, result, flags, crc, err_valid, err_flags,
        input  res_ack, err_ack, busy, sout
    );
endinterface

// File: rtl/mtm_alu_serializer_frame_tx.sv
// Emits one 11-bit frame (start, type, D7..D0, stop), each bit held BIT_CYCLES clocks.
module mtm_alu_frame_tx
    import mtm_alu_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       type_i,
    input  logic [7:0] byte_i,
    output logic       sout_o,
    output logic       done_o
);

    localparam logic [7:0] CYC_LAST = 8'(BIT_CYCLES - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    logic       active_q, active_d;
    logic       sout_q, sout_d;
    logic [9:0] frame_q, frame_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] cyc_cnt_q, cyc_cnt_d;
    logic       bit_end;

    assign bit_end = active_q && (cyc_cnt_q == 8'd0);
    assign done_o  = bit_end && (bit_cnt_q == BIT_LAST);
    assign sout_o  = sout_q;

    // A load on the done edge chains frames back-to-back without an idle bit.
    always_comb begin
        active_d  = active_q;
        sout_d    = sout_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        if (load_i) begin
            active_d  = 1'b1;
            sout_d    = START;
            frame_d   = {type_i, byte_i, STOP};
            bit_cnt_d = 4'd0;
            cyc_cnt_d = CYC_LAST;
        end else if (done_o) begin
            active_d  = 1'b0;
            sout_d    = STOP;
            bit_cnt_d = 4'd0;
        end else if (bit_end) begin
            sout_d    = frame_q[9];
            frame_d   = {frame_q[8:0], STOP};
            bit_cnt_d = bit_cnt_q + 4'd1;
            cyc_cnt_d = CYC_LAST;
        end else if (active_q) begin
            cyc_cnt_d = cyc_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q  <= 1'b0;
            sout_q    <= STOP;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            cyc_cnt_q <= '0;
        end else begin
            active_q  <= active_d;
            sout_q    <= sout_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Captures one ALU response (normal or error) and sequences its frames onto the serial line.
module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input logic                 clk,
    input logic                 rst,
    mtm_alu_serializer_if.slave bus
);

    state_e      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic [7:0]  ctl_q, ctl_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        res_ack_q, res_ack_d;
    logic        err_ack_q, err_ack_d;

    logic        tx_load;
    logic        tx_type;
    logic [7:0]  tx_byte;
    logic        tx_sout;
    logic        tx_done;

    mtm_alu_frame_tx #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_frame_tx (
        .clk    (clk),
        .rst    (rst),
        .load_i (tx_load),
        .type_i (tx_type),
        .byte_i (tx_byte),
        .sout_o (tx_sout),
        .done_o (tx_done)
    );

    assign bus.sout    = tx_sout;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.res_ack = res_ack_q;
    assign bus.err_ack = err_ack_q;

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        ctl_d      = ctl_q;
        byte_cnt_d = byte_cnt_q;
        res_ack_d  = 1'b0;
        err_ack_d  = 1'b0;
        tx_load    = 1'b0;
        tx_type    = TYPE_DATA;
        tx_byte    = 8'h00;
        case (state_q)
            ST_IDLE: begin
                // Errors win over a simultaneous result; the held result goes out afterwards.
                if (bus.err_valid) begin
                    ctl_d     = err_ctl_byte(bus.err_flags);
                    err_ack_d = 1'b1;
                    tx_load   = 1'b1;
                    tx_type   = TYPE_CTL;
                    tx_byte   = err_ctl_byte(bus.err_flags);
                    state_d   = ST_SEND_CTL;
                end else if (bus.res_valid) begin
                    result_d   = bus.result;
                    ctl_d      = norm_ctl_byte(bus.flags, bus.crc);
                    byte_cnt_d = 2'd0;
                    res_ack_d  = 1'b1;
                    tx_load    = 1'b1;
                    tx_type    = TYPE_DATA;
                    tx_byte    = result_byte(bus.result, 2'd0);
                    state_d    = ST_SEND_DATA;
                end
            end
            ST_SEND_DATA: begin
                if (tx_done) begin
                    tx_load = 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        tx_type = TYPE_CTL;
                        tx_byte = ctl_q;
                        state_d = ST_SEND_CTL;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        tx_type    = TYPE_DATA;
                        tx_byte    = result_byte(result_q, byte_cnt_q + 2'd1);
                    end
                end
            end
            ST_SEND_CTL: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            result_q   <= '0;
            ctl_q      <= '0;
            byte_cnt_q <= '0;
            res_ack_q  <= 1'b0;
            err_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            ctl_q      <= ctl_d;
            byte_cnt_q <= byte_cnt_d;
            res_ack_q  <= res_ack_d;
            err_ack_q  <= err_ack_d;
        end
    end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed bench: DUT a runs BIT_CYCLES=1, DUT b runs BIT_CYCLES=4; both share clk/rst.
module tb_mtm_alu_serializer;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    mtm_alu_serializer_if if_a ();
    mtm_alu_serializer_if if_b ();

    mtm_alu_serializer #(.BIT_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    mtm_alu_serializer #(.BIT_CYCLES(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [10:0] mk(input logic t, input logic [7:0] b);
        return {1'b0, t, b, 1'b1};
    endfunction

    function automatic logic sout_of(input int sel);
        return (sel != 0) ? if_b.sout : if_a.sout;
    endfunction
    function automatic logic busy_of(input int sel);
        return (sel != 0) ? if_b.busy : if_a.busy;
    endfunction
    function automatic logic rack_of(input int sel);
        return (sel != 0) ? if_b.res_ack : if_a.res_ack;
    endfunction
    function automatic logic eack_of(input int sel);
        return (sel != 0) ? if_b.err_ack : if_a.err_ack;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input int sel, input logic rv, input logic [31:0] r, input logic [3:0] fl,
                         input logic [2:0] c, input logic ev, input logic [2:0] ef);
        if (sel != 0) begin
            if_b.res_valid = rv; if_b.result = r; if_b.flags = fl;
            if_b.crc = c; if_b.err_valid = ev; if_b.err_flags = ef;
        end else begin
            if_a.res_valid = rv; if_a.result = r; if_a.flags = fl;
            if_a.crc = c; if_a.err_valid = ev; if_a.err_flags = ef;
        end
    endtask

    // Raise res_valid, check the ack cycle, then scramble inputs to prove they are shadowed.
    task automatic start_normal(input int sel, input logic [31:0] r, input logic [3:0] fl,
                                input logic [2:0] c, input string tag);
        drive(sel, 1'b1, r, fl, c, 1'b0, 3'b000);
        @(negedge clk);
        check({tag, "_res_ack"}, rack_of(sel), 1'b1);
        check({tag, "_err_ack"}, eack_of(sel), 1'b0);
        check({tag, "_busy"}, busy_of(sel), 1'b1);
        check({tag, "_start"}, sout_of(sel), 1'b0);
        drive(sel, 1'b0, ~r, ~fl, ~c, 1'b0, 3'b000);
    endtask

    // Called at the first bit cycle; returns at the cycle after the final stop bit.
    task automatic run_frames(input int sel, input int bc, input int n, input logic [10:0] exp [5],
                              input int exp_ra, input int exp_ea, input string tag);
        int         ra;
        int         ea;
        logic       busy_ok;
        logic       stable;
        logic       first;
        logic [10:0] fr;
        ra = 0; ea = 0; busy_ok = 1'b1; stable = 1'b1; first = 1'b0;
        for (int f = 0; f < n; f++) begin
            fr = '0;
            for (int b = 0; b < 11; b++) begin
                for (int c = 0; c < bc; c++) begin
                    if (c == 0) begin
                        first = sout_of(sel);
                        fr = {fr[9:0], first};
                    end else if (sout_of(sel) !== first) begin
                        stable = 1'b0;
                    end
                    if (busy_of(sel) !== 1'b1) busy_ok = 1'b0;
                    if (rack_of(sel) === 1'b1) ra++;
                    if (eack_of(sel) === 1'b1) ea++;
                    @(negedge clk);
                end
            end
            check($sformatf("%s_frame%0d", tag, f), fr, exp[f]);
        end
        check({tag, "_bit_stable"}, stable, 1'b1);
        check({tag, "_busy_held"}, busy_ok, 1'b1);
        check({tag, "_res_ack_count"}, ra, exp_ra);
        check({tag, "_err_ack_count"}, ea, exp_ea);
        check({tag, "_busy_done"}, busy_of(sel), 1'b0);
        check({tag, "_idle_high"}, sout_of(sel), 1'b1);
    endtask

    logic [10:0] fr5 [5];

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 32'h0, 4'h0, 3'h0, 1'b0, 3'h0);
        drive(1, 1'b0, 32'h0, 4'h0, 3'h0, 1'b0, 3'h0);
        repeat (2) @(negedge clk);
        check("rst_sout", if_a.sout, 1'b1);
        check("rst_busy", if_a.busy, 1'b0);
        check("rst_res_ack", if_a.res_ack, 1'b0);
        check("rst_err_ack", if_a.err_ack, 1'b0);
        check("rst_b_sout", if_b.sout, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Normal response 0x12345678, CTL = {0,0000,011} = 0x03
        fr5[0] = mk(1'b0, 8'h12); fr5[1] = mk(1'b0, 8'h34); fr5[2] = mk(1'b0, 8'h56);
        fr5[3] = mk(1'b0, 8'h78); fr5[4] = mk(1'b1, 8'h03);
        start_normal(0, 32'h12345678, 4'b0000, 3'b011, "norm");
        run_frames(0, 1, 5, fr5, 1, 0, "norm");
        @(negedge clk);

        // Zero result, CTL = {0,0100,101} = 0x25
        fr5[0] = mk(1'b0, 8'h00); fr5[1] = mk(1'b0, 8'h00); fr5[2] = mk(1'b0, 8'h00);
        fr5[3] = mk(1'b0, 8'h00); fr5[4] = mk(1'b1, 8'h25);
        start_normal(0, 32'h0, 4'b0100, 3'b101, "zero");
        run_frames(0, 1, 5, fr5, 1, 0, "zero");

        // Error response 001 -> 0x93
        drive(0, 1'b0, 32'h0, 4'h0, 3'h0, 1'b1, 3'b001);
        @(negedge clk);
        check("err_err_ack", if_a.err_ack, 1'b1);
        check("err_res_ack", if_a.res_ack, 1'b0);
        drive(0, 1'b0, 32'h0, 4'h0, 3'h0, 1'b0, 3'b110);
        fr5[0] = mk(1'b1, 8'h93);
        run_frames(0, 1, 1, fr5, 0, 1, "err");

        // Simultaneous: error 110 -> 0xED first, then result 0xA5C30F81, CTL {0,1011,010} = 0x5A
        drive(0, 1'b1, 32'hA5C30F81, 4'b1011, 3'b010, 1'b1, 3'b110);
        @(negedge clk);
        check("sim_err_ack", if_a.err_ack, 1'b1);
        check("sim_res_ack_first", if_a.res_ack, 1'b0);
        if_a.err_valid = 1'b0;
        if_a.err_flags = 3'b000;
        fr5[0] = mk(1'b1, 8'hED);
        run_frames(0, 1, 1, fr5, 0, 1, "sim_err");
        @(negedge clk);
        check("sim_res_ack", if_a.res_ack, 1'b1);
        check("sim_busy", if_a.busy, 1'b1);
        drive(0, 1'b0, 32'h0, 4'h0, 3'h0, 1'b0, 3'h0);
        fr5[0] = mk(1'b0, 8'hA5); fr5[1] = mk(1'b0, 8'hC3); fr5[2] = mk(1'b0, 8'h0F);
        fr5[3] = mk(1'b0, 8'h81); fr5[4] = mk(1'b1, 8'h5A);
        run_frames(0, 1, 5, fr5, 1, 0, "sim_res");
        @(negedge clk);

        // Reset during bit 5 of DATA byte 2 (bit value 1 of frame 0_0_01010110_1)
        start_normal(0, 32'h12345678, 4'b0000, 3'b011, "mid");
        repeat (27) @(negedge clk);
        check("mid_bit5", if_a.sout, 1'b1);
        check("mid_busy_before", if_a.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_sout", if_a.sout, 1'b1);
        check("mid_rst_busy", if_a.busy, 1'b0);
        check("mid_rst_res_ack", if_a.res_ack, 1'b0);
        check("mid_rst_err_ack", if_a.err_ack, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_after_idle", if_a.sout, 1'b1);

        // Fresh response 0xDEADBEEF, CTL {0,1000,111} = 0x47
        fr5[0] = mk(1'b0, 8'hDE); fr5[1] = mk(1'b0, 8'hAD); fr5[2] = mk(1'b0, 8'hBE);
        fr5[3] = mk(1'b0, 8'hEF); fr5[4] = mk(1'b1, 8'h47);
        start_normal(0, 32'hDEADBEEF, 4'b1000, 3'b111, "fresh");
        run_frames(0, 1, 5, fr5, 1, 0, "fresh");

        // BIT_CYCLES=4: same normal response, 220 cycles
        fr5[0] = mk(1'b0, 8'h12); fr5[1] = mk(1'b0, 8'h34); fr5[2] = mk(1'b0, 8'h56);
        fr5[3] = mk(1'b0, 8'h78); fr5[4] = mk(1'b1, 8'h03);
        start_normal(1, 32'h12345678, 4'b0000, 3'b011, "bc4");
        run_frames(1, 4, 5, fr5, 1, 0, "bc4");
        check("bc4_a_idle", if_a.busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
